// File: rtl/loss_seq_ctrl_pkg.sv
// Shared Q8.8 types, FSM state encoding and the saturating fixed-point helpers
// used by the loss sequencer and its arithmetic child.
package loss_seq_ctrl_pkg;

  localparam int FRAC_BITS = 8;

  typedef logic signed [15:0] q88_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam q88_t Q_MAX = 16'sh7FFF;
  localparam q88_t Q_MIN = 16'sh8000;

  function automatic q88_t q_sub(input q88_t a, input q88_t b);
    logic signed [16:0] d;
    d = {a[15], a} - {b[15], b};
    if (d > 17'sd32767) return Q_MAX;
    if (d < -17'sd32768) return Q_MIN;
    return d[15:0];
  endfunction

  // Product is floored (arithmetic shift), then saturated to Q8.8.
  function automatic q88_t q_mul(input q88_t a, input q88_t b);
    logic signed [31:0] p;
    p = 32'(a) * 32'(b);
    p = p >>> FRAC_BITS;
    if (p > 32'sd32767) return Q_MAX;
    if (p < -32'sd32768) return Q_MIN;
    return p[15:0];
  endfunction

endpackage

// File: rtl/loss_seq_ctrl_loss_child.sv
// One-stage registered gradient unit: grad = (H - Y) * (2/N) in Q8.8.
module loss_seq_ctrl_loss_child
  import loss_seq_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [15:0] i_h,
  input  logic [15:0] i_y,
  input  logic [15:0] i_inv,
  output logic        o_valid,
  output logic [15:0] o_grad
);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_grad  <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) o_grad <= q_mul(q_sub(i_h, i_y), i_inv);
    end
  end

endmodule

// File: rtl/loss_seq_ctrl.sv
// Batch sequencer: reads H/Y pairs, computes loss gradients, and writes them
// through a credit-protected skid FIFO so a stalled sink never drops data.
module loss_seq_ctrl
  import loss_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int LEN_W     = 8,
  parameter int OUT_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  batch_len,
  input  logic [15:0]       inv_batch_size_times_two_in,
  input  logic [ADDR_W-1:0] h_base,
  input  logic [ADDR_W-1:0] y_base,
  input  logic [ADDR_W-1:0] g_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_h,
  output logic [ADDR_W-1:0] rd_addr_y,
  input  logic [15:0]       rd_h_data,
  input  logic [15:0]       rd_y_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done
);

  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;

  state_t            r_state;
  logic [LEN_W-1:0]  r_len, r_issue_cnt, r_wr_cnt;
  logic [ADDR_W-1:0] r_h_base, r_y_base, r_g_base;
  logic [15:0]       r_inv;
  logic [CW-1:0]     r_credit_used;
  logic [CW-1:0]     r_occ;
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [15:0]       r_mem [OUT_DEPTH];
  logic              r_rd_vld;

  logic              w_issue, w_push, w_pop, w_last_issue, w_last_wr;
  logic [15:0]       w_grad;

  // Credit covers everything issued but not yet accepted by the sink, so the
  // FIFO can always absorb whatever is still in the read/loss pipeline.
  assign w_issue      = (r_state == S_ISSUE) && (r_credit_used < CW'(OUT_DEPTH));
  assign w_last_issue = w_issue && (r_issue_cnt == r_len - LEN_W'(1));
  assign w_pop        = (r_occ != '0) && wr_ready;
  assign w_last_wr    = w_pop && (r_wr_cnt == r_len - LEN_W'(1));

  assign rd_en     = w_issue;
  assign rd_addr_h = r_h_base + ADDR_W'(r_issue_cnt);
  assign rd_addr_y = r_y_base + ADDR_W'(r_issue_cnt);
  assign wr_en     = (r_occ != '0);
  assign wr_addr   = r_g_base + ADDR_W'(r_wr_cnt);
  assign wr_data   = wr_en ? r_mem[r_rptr] : '0;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_wr_cnt    <= '0;
      r_h_base    <= '0;
      r_y_base    <= '0;
      r_g_base    <= '0;
      r_inv       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_len       <= batch_len;
          r_inv       <= inv_batch_size_times_two_in;
          r_h_base    <= h_base;
          r_y_base    <= y_base;
          r_g_base    <= g_base;
          r_issue_cnt <= '0;
          r_wr_cnt    <= '0;
          r_state     <= (batch_len == '0) ? S_DONE : S_ISSUE;
        end
        S_ISSUE: if (w_last_issue) r_state <= S_DRAIN;
        S_DRAIN: if (w_last_wr) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_issue) r_issue_cnt <= r_issue_cnt + LEN_W'(1);
      if (w_pop)   r_wr_cnt    <= r_wr_cnt + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_vld      <= 1'b0;
      r_credit_used <= '0;
      r_occ         <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_rd_vld      <= w_issue;
      r_credit_used <= r_credit_used + CW'(w_issue) - CW'(w_pop);
      r_occ         <= r_occ + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_grad;
  end

  loss_seq_ctrl_loss_child u_loss_child (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_valid (r_rd_vld),
    .i_h     (rd_h_data),
    .i_y     (rd_y_data),
    .i_inv   (r_inv),
    .o_valid (w_push),
    .o_grad  (w_grad)
  );

endmodule
